// File: rtl/input_quant_packer_pkg.sv
// Shared constants and types for the layer-0 input quantiser/packer.
// Holds default geometry, the threshold word type and the fill-control state encoding.
package ln_input_pkg;

  localparam int unsigned IN_W         = 8;
  localparam int unsigned Q_W          = 2;
  localparam int unsigned NT           = 2**Q_W - 1;
  localparam int unsigned NUM_FEATURES = 3;

  typedef logic [IN_W-1:0] thr_t;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

endpackage

// File: rtl/input_quant_packer_quant_cell.sv
// Combinational quantiser: code = number of thresholds the value meets or exceeds.
// Thresholds need not be sorted; the count definition holds for any ordering.
module quant_cell #(
  parameter int unsigned IN_W = ln_input_pkg::IN_W,
  parameter int unsigned Q_W  = ln_input_pkg::Q_W,
  parameter int unsigned NT   = 2**Q_W - 1
) (
  input  logic [IN_W-1:0] value_i,
  input  logic [IN_W-1:0] thr_i [NT],
  output logic [Q_W-1:0]  code_o
);

  always_comb begin
    code_o = '0;
    for (int unsigned t = 0; t < NT; t++) begin
      if (value_i >= thr_i[t]) code_o = code_o + Q_W'(1);
    end
  end

endmodule

// File: rtl/input_quant_packer.sv
// Streaming feature quantiser/packer: one raw feature per beat in, one packed code frame out.
// Double-buffered (pack reg + output reg) so a new frame can fill while the output stalls.
module input_quant_packer #(
  parameter int unsigned NUM_FEATURES = ln_input_pkg::NUM_FEATURES,
  parameter int unsigned IN_W         = ln_input_pkg::IN_W,
  parameter int unsigned Q_W          = ln_input_pkg::Q_W,
  localparam int unsigned NT          = 2**Q_W - 1,
  localparam int unsigned NTH         = NUM_FEATURES * NT,
  localparam int unsigned AW          = (NTH > 1) ? $clog2(NTH) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [IN_W-1:0]             s_data,
  input  logic                        s_last,
  input  logic                        thr_we,
  input  logic [AW-1:0]               thr_addr,
  input  logic [IN_W-1:0]             thr_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [NUM_FEATURES*Q_W-1:0] m_data,
  output logic                        err_len,
  output logic [15:0]                 frame_cnt
);

  import ln_input_pkg::*;

  localparam int unsigned IDX_W    = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
  localparam int unsigned FW       = NUM_FEATURES * Q_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [FW-1:0]      pack_q, pack_d;
  logic [FW-1:0]      out_q, out_d;
  logic               mv_q, mv_d;
  logic               err_q, err_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [IN_W-1:0]    thr_q [NTH];
  logic [IN_W-1:0]    thr_sel [NT];
  logic [Q_W-1:0]     code;
  logic               drain;

  assign s_ready   = (state_q == FILL);
  assign drain     = mv_q & m_ready;
  assign m_valid   = mv_q;
  assign m_data    = out_q;
  assign err_len   = err_q;
  assign frame_cnt = cnt_q;

  // Out-of-range addresses are dropped rather than aliased onto a real entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NTH; i++) thr_q[i] <= '0;
    end else if (thr_we && (32'(thr_addr) < NTH)) begin
      thr_q[thr_addr] <= thr_data;
    end
  end

  always_comb begin
    for (int unsigned t = 0; t < NT; t++) begin
      thr_sel[t] = thr_q[AW'(32'(idx_q) * NT + t)];
    end
  end

  quant_cell #(
    .IN_W (IN_W),
    .Q_W  (Q_W),
    .NT   (NT)
  ) u_quant (
    .value_i (s_data),
    .thr_i   (thr_sel),
    .code_o  (code)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      idx_q   <= '0;
      pack_q  <= '0;
      out_q   <= '0;
      mv_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pack_q  <= pack_d;
      out_q   <= out_d;
      mv_q    <= mv_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pack_d  = pack_q;
    out_d   = out_q;
    mv_d    = mv_q & ~drain;
    err_d   = 1'b0;
    cnt_d   = drain ? cnt_q + 16'd1 : cnt_q;

    case (state_q)
      FILL: begin
        if (s_valid) begin
          for (int unsigned i = 0; i < NUM_FEATURES; i++) begin
            if (IDX_W'(i) == idx_q) pack_d[Q_W*i +: Q_W] = code;
          end
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            err_d = ~s_last;
            // A same-cycle drain frees the output reg, so the frame bypasses FULL.
            if (!mv_q || m_ready) begin
              out_d = pack_d;
              mv_d  = 1'b1;
            end else begin
              state_d = FULL;
            end
          end else if (s_last) begin
            idx_d = '0;
            err_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      FULL: begin
        if (m_ready) begin
          out_d   = pack_q;
          mv_d    = 1'b1;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

endmodule

// File: tb/tb_input_quant_packer.sv
// Scoreboard bench for input_quant_packer: driver feeds a count-of-thresholds reference model,
// monitor pops expected frames/err pulses whenever the DUT hands data over.
module tb_input_quant_packer;

  logic        clk;
  logic        rst_n;
  logic        s_valid, s_ready, s_last;
  logic [7:0]  s_data;
  logic        thr_we;
  logic [3:0]  thr_addr;
  logic [7:0]  thr_data;
  logic        m_valid, m_ready;
  logic [5:0]  m_data;
  logic        err_len;
  logic [15:0] frame_cnt;

  logic        w_s_valid, w_s_ready, w_s_last;
  logic [7:0]  w_s_data;
  logic        w_thr_we;
  logic [1:0]  w_thr_addr;
  logic [7:0]  w_thr_data;
  logic        w_m_valid, w_m_ready;
  logic [1:0]  w_m_data;
  logic        w_err_len;
  logic [15:0] w_frame_cnt;

  input_quant_packer #(.NUM_FEATURES(3), .IN_W(8), .Q_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .thr_we(thr_we), .thr_addr(thr_addr), .thr_data(thr_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .err_len(err_len), .frame_cnt(frame_cnt)
  );

  // Single-feature instance: one beat per frame makes the 16-bit counter wrap affordable.
  input_quant_packer #(.NUM_FEATURES(1), .IN_W(8), .Q_W(2)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .s_valid(w_s_valid), .s_ready(w_s_ready), .s_data(w_s_data), .s_last(w_s_last),
    .thr_we(w_thr_we), .thr_addr(w_thr_addr), .thr_data(w_thr_data),
    .m_valid(w_m_valid), .m_ready(w_m_ready), .m_data(w_m_data),
    .err_len(w_err_len), .frame_cnt(w_frame_cnt)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rdy_mode = 1;
  bit mon_en = 0;

  int ref_thr [9];
  int cur_codes [$];
  logic [5:0] exp_q [$];
  int err_q [$];
  int prev_pop = 0, last_pop = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: code = how many of the feature's thresholds the value reaches.
  task automatic model_accept(input int d, input bit last);
    int f = cur_codes.size();
    int code = 0;
    int frame = 0;
    for (int t = 0; t < 3; t++) if (d >= ref_thr[f*3 + t]) code++;
    cur_codes.push_back(code);
    if (cur_codes.size() == 3) begin
      for (int i = 0; i < 3; i++) frame += cur_codes[i] * (4 ** i);
      exp_q.push_back(6'(frame));
      if (!last) err_q.push_back(cyc + 1);
      cur_codes.delete();
    end else if (last) begin
      err_q.push_back(cyc + 1);
      cur_codes.delete();
    end
  endtask

  task automatic send(input int d, input bit last);
    int n = 0;
    s_valid = 1'b1;
    s_data  = 8'(d);
    s_last  = last;
    while (!s_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("s_ready_timeout", 32'(n < 500), 32'd1);
    model_accept(d, last);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wr_thr(input int addr, input int data);
    thr_we   = 1'b1;
    thr_addr = 4'(addr);
    thr_data = 8'(data);
    @(negedge clk);
    thr_we = 1'b0;
    if (addr < 9) ref_thr[addr] = data;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       m_ready = 1'b0;
        1:       m_ready = 1'b1;
        default: m_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  initial begin : monitor
    logic [15:0] exp_cnt;
    logic        prev_v, prev_r, have_prev, exp_err;
    logic [5:0]  prev_d;
    exp_cnt = '0;
    have_prev = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n || !mon_en) begin
        exp_cnt = '0;
        have_prev = 1'b0;
        continue;
      end
      check("frame_cnt", frame_cnt, exp_cnt);
      exp_err = (err_q.size() > 0 && err_q[0] == cyc);
      if (exp_err) void'(err_q.pop_front());
      check("err_len", err_len, exp_err);
      if (have_prev && prev_v && !prev_r) begin
        check("m_valid_hold", m_valid, 1);
        check("m_data_hold", m_data, prev_d);
      end
      if (m_valid && exp_q.size() == 0) check("spurious_m_valid", m_valid, 0);
      if (m_valid && m_ready && exp_q.size() > 0) begin
        check("m_data", m_data, exp_q.pop_front());
        exp_cnt = exp_cnt + 16'd1;
        prev_pop = last_pop;
        last_pop = cyc;
      end
      prev_v = m_valid;
      prev_r = m_ready;
      prev_d = m_data;
      have_prev = 1'b1;
    end
  end

  initial begin : watchdog
    #5ms;
    failures++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int hs, n;
    bit last;
    rst_n = 1'b0;
    s_valid = 0; s_data = 0; s_last = 0;
    thr_we = 0; thr_addr = 0; thr_data = 0;
    w_s_valid = 0; w_s_data = 0; w_s_last = 1; w_thr_we = 0; w_thr_addr = 0; w_thr_data = 0;
    w_m_ready = 1;
    foreach (ref_thr[i]) ref_thr[i] = 0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_s_ready", s_ready, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_err_len", err_len, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // Basic frame, thresholds {64,128,192} on every feature
    for (int f = 0; f < 3; f++)
      for (int t = 0; t < 3; t++) wr_thr(f*3 + t, (t + 1) * 64);
    send(10, 0); send(100, 0); send(200, 1);
    #1;
    check("latency_m_valid", m_valid, 1);
    check("basic_m_data", m_data, 6'b11_01_00);
    @(negedge clk);
    #1;
    check("frame_cnt_one", frame_cnt, 1);
    @(negedge clk);

    // Threshold equality boundaries
    send(64, 0); send(127, 0); send(255, 1);

    // Out-of-range threshold addresses are ignored
    wr_thr(9, 0);
    wr_thr(15, 255);
    send(10, 0); send(100, 0); send(200, 1);

    // Write to feature 0 in the same cycle it is accepted: old threshold applies
    thr_we = 1'b1; thr_addr = 4'd0; thr_data = 8'd255;
    send(64, 0);
    thr_we = 1'b0;
    ref_thr[0] = 255;
    send(128, 0); send(0, 1);
    send(64, 0); send(0, 0); send(0, 1);

    // Early s_last, then a clean frame, then a missing s_last
    send(5, 0); send(6, 1);
    send(10, 0); send(100, 0); send(200, 1);
    send(10, 0); send(100, 0); send(200, 0);
    wait_drain();

    // Output stall: frame A held, frame B fills the pack reg
    rdy_mode = 0;
    @(negedge clk);
    send(200, 0); send(200, 0); send(200, 1);
    send(255, 0); send(150, 0); send(70, 1);
    #1;
    check("stall_s_ready", s_ready, 0);
    check("stall_m_valid", m_valid, 1);
    check("stall_m_data", m_data, 6'h3E);
    repeat (3) @(negedge clk);
    #1;
    check("stall_still_full", s_ready, 0);
    @(negedge clk);
    rdy_mode = 1;
    wait_drain();
    #1;
    check("after_drain_s_ready", s_ready, 1);
    check("back_to_back", last_pop - prev_pop, 1);
    @(negedge clk);

    // Randomised traffic with random back-pressure, length errors and threshold updates
    rdy_mode = 2;
    for (int b = 0; b < 150; b++) begin
      if ($urandom_range(0, 9) == 0) wr_thr($urandom_range(0, 8), $urandom_range(0, 255));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      last = (cur_codes.size() == 2);
      if ($urandom_range(0, 14) == 0) last = !last;
      send($urandom_range(0, 255), last);
    end
    while (cur_codes.size() != 0) send($urandom_range(0, 255), cur_codes.size() == 2);
    rdy_mode = 1;
    wait_drain();
    @(negedge clk);
    check("err_pending", err_q.size(), 0);

    // Reset with a frame on the output and a partial frame in progress
    rdy_mode = 0;
    @(negedge clk);
    send(1, 0); send(2, 0); send(3, 1);
    send(4, 0);
    rst_n = 1'b0;
    mon_en = 1'b0;
    exp_q.delete();
    err_q.delete();
    cur_codes.delete();
    foreach (ref_thr[i]) ref_thr[i] = 0;
    #1;
    check("midrst_m_valid", m_valid, 0);
    check("midrst_s_ready", s_ready, 1);
    check("midrst_m_data", m_data, 0);
    check("midrst_frame_cnt", frame_cnt, 0);
    @(negedge clk);
    #1;
    check("midrst_err_len", err_len, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    rdy_mode = 1;
    @(negedge clk);
    send(10, 0); send(100, 0); send(200, 1);
    #1;
    check("post_rst_m_data", m_data, 6'b11_11_11);
    @(negedge clk);
    wait_drain();

    // frame_cnt wrap on the single-feature instance
    w_s_valid = 1'b1;
    hs = 0;
    n = 0;
    while (hs < 65535 && n < 70000) begin
      @(negedge clk);
      #1;
      if (w_m_valid && w_m_ready) hs++;
      n++;
    end
    check("wrap_timeout", 32'(n < 70000), 32'd1);
    @(negedge clk);
    #1;
    check("wrap_ffff", w_frame_cnt, 16'hFFFF);
    check("wrap_m_data", w_m_data, 2'b11);
    check("wrap_m_valid", w_m_valid, 1);
    @(negedge clk);
    #1;
    check("wrap_zero", w_frame_cnt, 16'h0000);
    @(negedge clk);
    w_s_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
